// File: rtl/mat2x2_pkg.sv
// Shared types and field layout for the 2x2 matrix-multiply job scheduler.
package mat2x2_pkg;

  localparam int unsigned OP_W      = 8;
  localparam int unsigned RES_W     = 17;
  localparam int unsigned OPS_W     = 8 * OP_W;
  localparam int unsigned RES_BUS_W = 4 * RES_W;
  localparam int unsigned CNT_W     = 8;

  // Operand word layout {b11,b10,b01,b00,a11,a10,a01,a00}
  localparam int unsigned A00_LSB = 0;
  localparam int unsigned A01_LSB = 8;
  localparam int unsigned A10_LSB = 16;
  localparam int unsigned A11_LSB = 24;
  localparam int unsigned B00_LSB = 32;
  localparam int unsigned B01_LSB = 40;
  localparam int unsigned B10_LSB = 48;
  localparam int unsigned B11_LSB = 56;

  // Result word layout {c3,c2,c1,c0}
  localparam int unsigned C0_LSB = 0;
  localparam int unsigned C1_LSB = 17;
  localparam int unsigned C2_LSB = 34;
  localparam int unsigned C3_LSB = 51;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer flips away from the winner on each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_idx_c,
  output logic       gnt_any_c
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_any_c = |req;
    gnt_idx_c = req[ptr_q] ? ptr_q : ~ptr_q;
    ptr_d     = advance ? ~gnt_idx_c : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mat2x2_job_sched.sv
// Schedules 2x2 multiply jobs from two requesters onto one external engine,
// with round-robin grant, done-edge detection and a WAIT timeout.
module mat2x2_job_sched
  import mat2x2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [OPS_W-1:0]     req_op0,
  input  logic [OPS_W-1:0]     req_op1,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [RES_BUS_W-1:0] rsp_res,
  output logic                 rsp_err,
  output logic                 eng_start,
  output logic [OP_W-1:0]      eng_a00,
  output logic [OP_W-1:0]      eng_a01,
  output logic [OP_W-1:0]      eng_a10,
  output logic [OP_W-1:0]      eng_a11,
  output logic [OP_W-1:0]      eng_b00,
  output logic [OP_W-1:0]      eng_b01,
  output logic [OP_W-1:0]      eng_b10,
  output logic [OP_W-1:0]      eng_b11,
  input  logic [RES_W-1:0]     eng_c0,
  input  logic [RES_W-1:0]     eng_c1,
  input  logic [RES_W-1:0]     eng_c2,
  input  logic [RES_W-1:0]     eng_c3,
  input  logic                 eng_done
);

  state_e               state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic [OPS_W-1:0]     ops_q, ops_d;
  logic                 eng_start_q, eng_start_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_prev_q, done_prev_d;
  logic [1:0]           rsp_valid_q, rsp_valid_d;
  logic [RES_BUS_W-1:0] rsp_res_q, rsp_res_d;
  logic                 rsp_err_q, rsp_err_d;

  logic gnt_idx_c, gnt_any_c, grant_c, done_rise_c;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (grant_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c)
  );

  // Ready is only offered in the IDLE cycle that makes the grant.
  assign grant_c     = (state_q == ST_IDLE) && gnt_any_c;
  assign req_ready   = grant_c ? (gnt_idx_c ? 2'b10 : 2'b01) : 2'b00;
  assign done_rise_c = eng_done && !done_prev_q;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ops_d       = ops_q;
    eng_start_d = 1'b0;
    cnt_d       = cnt_q;
    done_prev_d = eng_done;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          gnt_d       = gnt_idx_c;
          ops_d       = gnt_idx_c ? req_op1 : req_op0;
          eng_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise_c) begin
          rsp_res_d[C0_LSB +: RES_W] = eng_c0;
          rsp_res_d[C1_LSB +: RES_W] = eng_c1;
          rsp_res_d[C2_LSB +: RES_W] = eng_c2;
          rsp_res_d[C3_LSB +: RES_W] = eng_c3;
          rsp_err_d   = 1'b0;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_res_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if ((rsp_valid_q & rsp_ready) != 2'b00) begin
          rsp_valid_d = 2'b00;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      ops_q       <= '0;
      eng_start_q <= 1'b0;
      cnt_q       <= '0;
      done_prev_q <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ops_q       <= ops_d;
      eng_start_q <= eng_start_d;
      cnt_q       <= cnt_d;
      done_prev_q <= done_prev_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign eng_start = eng_start_q;
  assign eng_a00   = ops_q[A00_LSB +: OP_W];
  assign eng_a01   = ops_q[A01_LSB +: OP_W];
  assign eng_a10   = ops_q[A10_LSB +: OP_W];
  assign eng_a11   = ops_q[A11_LSB +: OP_W];
  assign eng_b00   = ops_q[B00_LSB +: OP_W];
  assign eng_b01   = ops_q[B01_LSB +: OP_W];
  assign eng_b10   = ops_q[B10_LSB +: OP_W];
  assign eng_b11   = ops_q[B11_LSB +: OP_W];
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mat2x2_job_sched.sv
// Scoreboard bench for mat2x2_job_sched with a behavioural multiply engine.
module tb_mat2x2_job_sched;

  localparam int unsigned TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_op0, req_op1;
  logic [67:0] rsp_res;
  logic        rsp_err, eng_start, eng_done;
  logic [7:0]  eng_a00, eng_a01, eng_a10, eng_a11, eng_b00, eng_b01, eng_b10, eng_b11;
  logic [16:0] eng_c0, eng_c1, eng_c2, eng_c3;

  mat2x2_job_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_err(rsp_err),
    .eng_start(eng_start),
    .eng_a00(eng_a00), .eng_a01(eng_a01), .eng_a10(eng_a10), .eng_a11(eng_a11),
    .eng_b00(eng_b00), .eng_b01(eng_b01), .eng_b10(eng_b10), .eng_b11(eng_b11),
    .eng_c0(eng_c0), .eng_c1(eng_c1), .eng_c2(eng_c2), .eng_c3(eng_c3),
    .eng_done(eng_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine: done drops lazily two cycles after start, so a stale high level overlaps early WAIT.
  logic [2:0] e_cnt;
  logic       e_hang;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_cnt <= 3'd0; eng_done <= 1'b0;
      eng_c0 <= '0; eng_c1 <= '0; eng_c2 <= '0; eng_c3 <= '0;
    end else if (eng_start) begin
      e_cnt <= 3'd6;
    end else if (e_cnt != 3'd0) begin
      e_cnt <= e_cnt - 3'd1;
      if (e_cnt == 3'd5) eng_done <= 1'b0;
      if (e_cnt == 3'd2 && !e_hang) begin
        eng_c0 <= 17'(eng_a00) * 17'(eng_b00) + 17'(eng_a01) * 17'(eng_b10);
        eng_c1 <= 17'(eng_a00) * 17'(eng_b01) + 17'(eng_a01) * 17'(eng_b11);
        eng_c2 <= 17'(eng_a10) * 17'(eng_b00) + 17'(eng_a11) * 17'(eng_b10);
        eng_c3 <= 17'(eng_a10) * 17'(eng_b01) + 17'(eng_a11) * 17'(eng_b11);
        eng_done <= 1'b1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [67:0] mm(input logic [63:0] op);
    logic [16:0] a00, a01, a10, a11, b00, b01, b10, b11;
    a00 = 17'(op[7:0]);   a01 = 17'(op[15:8]);  a10 = 17'(op[23:16]); a11 = 17'(op[31:24]);
    b00 = 17'(op[39:32]); b01 = 17'(op[47:40]); b10 = 17'(op[55:48]); b11 = 17'(op[63:56]);
    return {a10 * b01 + a11 * b11, a10 * b00 + a11 * b10,
            a00 * b01 + a01 * b11, a00 * b00 + a01 * b10};
  endfunction

  typedef struct {
    logic        idx;
    logic [67:0] res;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  // Push on accepted request, pop and compare on completed response.
  always @(negedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          exp_t e;
          e.idx = r[0];
          e.err = e_hang;
          e.res = e_hang ? 68'd0 : mm(r == 0 ? req_op0 : req_op1);
          exp_q.push_back(e);
        end
      end
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 68'(rsp_valid), 68'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_idx", 68'(rsp_valid), e.idx ? 68'd2 : 68'd1);
          check("rsp_res", rsp_res, e.res);
          check("rsp_err", 68'(rsp_err), 68'(e.err));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 68'(req_ready), 68'd0);
    check({tag, "_rsp_valid"}, 68'(rsp_valid), 68'd0);
    check({tag, "_rsp_res"}, rsp_res, 68'd0);
    check({tag, "_rsp_err"}, 68'(rsp_err), 68'd0);
    check({tag, "_eng_start"}, 68'(eng_start), 68'd0);
    check({tag, "_eng_ops"},
          68'({eng_b11, eng_b10, eng_b01, eng_b00, eng_a11, eng_a10, eng_a01, eng_a00}), 68'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] mask, output logic [1:0] first);
    logic [1:0] acc;
    int n = 0;
    first = 2'b00;
    req_valid = mask;
    while (req_valid != 2'b00 && n < 60) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (first == 2'b00) first = acc;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
      n++;
    end
    if (req_valid != 2'b00) begin
      check("accept_timeout", 68'(req_valid), 68'd0);
      req_valid = 2'b00;
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_seen"}, 68'(rsp_valid != 2'b00), 68'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid != 2'b00) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", 68'(exp_q.size()), 68'd0);
  endtask

  logic [1:0]  first;
  logic [63:0] op_bp;
  int          n;

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11; e_hang = 1'b0;
    req_op0 = '0; req_op1 = '0;

    do_reset();

    // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    req_op0 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send(2'b01, first);
    check("single_grant", 68'(first), 68'd1);
    wait_rsp("single");
    check("single_res", rsp_res, {17'd50, 17'd43, 17'd22, 17'd19});
    check("single_err", 68'(rsp_err), 68'd0);
    drain();

    // Both valid from reset: requester 0 first, then 1.
    do_reset();
    req_op0 = {8'd2, 8'd9, 8'd4, 8'd1, 8'd7, 8'd3, 8'd5, 8'd6};
    req_op1 = {8'd11, 8'd0, 8'd13, 8'd17, 8'd19, 8'd23, 8'd29, 8'd31};
    send(2'b11, first);
    check("rr_first", 68'(first), 68'd1);
    drain();

    // Full-scale operands.
    req_op1 = {8{8'hFF}};
    send(2'b10, first);
    wait_rsp("full");
    check("full_scale", rsp_res, {4{17'h1FC02}});
    drain();

    // Timeout with a hung engine.
    e_hang = 1'b1;
    req_op0 = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send(2'b01, first);
    n = 0;
    @(negedge clk);
    while (!eng_start && n < 10) begin @(negedge clk); n++; end
    check("start_seen", 68'(eng_start), 68'd1);
    n = 0;
    @(negedge clk);
    n++;
    check("start_pulse", 68'(eng_start), 68'd0);
    while (rsp_valid == 2'b00 && n < 300) begin @(negedge clk); n++; end
    check("timeout_lat", 68'(n), 68'(TIMEOUT + 1));
    check("timeout_res", rsp_res, 68'd0);
    check("timeout_err", 68'(rsp_err), 68'd1);
    drain();
    e_hang = 1'b0;

    // Back-pressure: response held while requester 1 waits.
    rsp_ready = 2'b00;
    op_bp = {8'd200, 8'd3, 8'd77, 8'd9, 8'd14, 8'd250, 8'd1, 8'd128};
    req_op0 = op_bp;
    req_op1 = {8'd5, 8'd5, 8'd5, 8'd5, 8'd6, 8'd6, 8'd6, 8'd6};
    send(2'b01, first);
    req_valid = 2'b10;
    wait_rsp("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 68'(rsp_valid), 68'd1);
      check("bp_res", rsp_res, mm(op_bp));
      check("bp_no_grant", 68'(req_ready), 68'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    send(2'b10, first);
    check("bp_next_grant", 68'(first), 68'd2);
    drain();

    // Reset in the middle of WAIT aborts silently, then a fresh job works.
    req_op0 = {8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
    send(2'b01, first);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    req_op0 = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    send(2'b01, first);
    wait_rsp("post_rst");
    check("post_rst_res", rsp_res, mm({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mat2x2_job_sched.md
MAT2X2_JOB_SCHED -- requirements
Module: mat2x2_job_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles in WAIT before a job is aborted (range 8..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have ports req_valid[1:0] and req_ready[1:0]: input and output, 2 bits each, per-requester job handshake (index = requester).
REQ-005 SHALL have ports req_op0 and req_op1: input, 64 bits each, operands packed {b11,b10,b01,b00,a11,a10,a01,a00}, with a00 in bits [7:0].
REQ-006 SHALL have ports rsp_valid[1:0] and rsp_ready[1:0]: output and input, 2 bits each, per-requester result handshake.
REQ-007 SHALL have port rsp_res: output, 68 bits, result packed {c3,c2,c1,c0}, with c0 in bits [16:0]; shared by both requesters.
REQ-008 SHALL have port rsp_err: output, 1 bit, qualifies rsp_res; 1 = job timed out.
REQ-009 SHALL have ports eng_start (output, 1) and eng_a00..eng_b11 (outputs, 8 bits each), driving the 2x2 multiply engine.
REQ-010 SHALL have ports eng_c0..eng_c3 (inputs, 17 bits each) and eng_done (input, 1), the engine results and done flag.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-012 IDLE: if any req_valid is set, SHALL grant one requester round-robin, latch its operands into the engine operand registers, and go to ISSUE.
REQ-013 Round-robin rule: the pointer names the preferred requester; if both are valid, the preferred one wins; the pointer SHALL move to the other requester after every grant.
REQ-014 req_ready[g] SHALL be 1 only in the IDLE cycle that grants requester g; the operands are accepted only when valid and ready are both high.
REQ-015 ISSUE: eng_start SHALL be 1 for exactly one cycle, then the FSM goes to WAIT.
REQ-016 The engine operand outputs SHALL stay constant from the grant until the FSM leaves WAIT.
REQ-017 WAIT: SHALL detect completion as a rising edge of eng_done (registered previous value is 0, current value is 1); a level-high eng_done carried over from an earlier job SHALL NOT count.
REQ-018 On completion, SHALL capture eng_c0..c3 into rsp_res, set rsp_err=0, and go to RESP.
REQ-019 WAIT counter: cleared on entry to WAIT; if it reaches TIMEOUT without completion, SHALL set rsp_res=0 and rsp_err=1, then go to RESP.
REQ-020 RESP: rsp_valid[g] SHALL be held at 1, with rsp_res and rsp_err stable, until rsp_ready[g] is sampled 1; then go to IDLE.
REQ-021 The grant SHALL happen no earlier than the cycle after IDLE is entered, so there is no back-to-back bypass.
REQ-022 rsp_valid[~g] and req_ready SHALL be 0 outside the cases above; a requester's request SHALL wait while the other requester's job is in flight.
REQ-023 No arithmetic is performed in this block; results SHALL pass through at the full 17 bits, with no truncation.

Reset
REQ-024 On rst: state=IDLE, pointer=0, eng_start=0, engine operands=0, rsp_valid=0, req_ready=0, rsp_res=0, rsp_err=0, WAIT counter=0, done-edge register=0.
REQ-025 Reset asserted mid-job SHALL abort the job with no response to the requester; the engine is reset by the same rst.

Structure
REQ-026 FSM state encoding, operand/result bit-field offsets, and the result width (17) SHALL live in a shared package, mat2x2_pkg.
REQ-027 SHALL instantiate the engine in the bench or the top level only, never inside this block; one sub-module, rr_arb2, SHALL implement the two-input round-robin grant.

Verification
REQ-028 Single job: requester 0 sends A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> rsp_valid[0] asserts with c0=19, c1=22, c2=43, c3=50, rsp_err=0.
REQ-029 Both requesters valid from reset with different operands -> requester 0 is served first, then requester 1; each receives its own correct result.
REQ-030 Full-scale operands: all elements 255 -> every result is 130050 (0x1FC02), with no truncation.
REQ-031 Timeout: bench model holds eng_done=0 -> after TIMEOUT cycles in WAIT, rsp_valid asserts with rsp_res=0 and rsp_err=1.
REQ-032 Back-pressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_res stay stable; no new grant is issued; the response completes when rsp_ready=1.
REQ-033 Reset mid-WAIT -> all outputs return to reset values; a subsequent job completes correctly, and the stale eng_done level is not treated as completion.
